// File: rtl/array_seq_pkg.sv
// Shared types for the systolic-array job sequencer: FSM state encoding and
// lane / row-vector types at the default array geometry.
package array_seq_pkg;

  localparam int SEQ_DATA_WIDTH = 8;
  localparam int SEQ_ARRAY_DIM  = 256;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } seq_state_t;

  typedef logic [SEQ_DATA_WIDTH-1:0] lane_t;
  typedef lane_t [SEQ_ARRAY_DIM-1:0] row_vec_t;

endpackage

// File: rtl/lane_skew.sv
// Triangular per-lane delay line. REVERSE=0: lane k delayed k cycles (skew);
// REVERSE=1: lane k delayed N-1-k cycles (deskew). Lanes with depth 0 pass through.
module lane_skew #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int REVERSE    = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N*DATA_WIDTH-1:0]   i_vec,
  output logic [N*DATA_WIDTH-1:0]   o_vec
);

  for (genvar k = 0; k < N; k++) begin : g_lane
    localparam int DEPTH = (REVERSE != 0) ? (N - 1 - k) : k;

    if (DEPTH == 0) begin : g_pass
      assign o_vec[k*DATA_WIDTH +: DATA_WIDTH] = i_vec[k*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] r_pipe [DEPTH];

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= i_vec[k*DATA_WIDTH +: DATA_WIDTH];
          for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign o_vec[k*DATA_WIDTH +: DATA_WIDTH] = r_pipe[DEPTH-1];
    end
  end

endmodule

// File: rtl/array_sequencer.sv
// Sequences one matrix job through the systolic array: weight load, skewed
// activation stream, deskewed result write-back. Optional ARRAY_SEQ_PERF_CNT_EN adds perf_cycles.
module array_sequencer
  import array_seq_pkg::*;
#(
  parameter int ARRAY_DIM  = 256,
  parameter int DATA_WIDTH = 8,
  parameter int ROWS_W     = 16,
  parameter int ARRAY_LAT  = 512
) (
  input  logic                            clk,
  input  logic                            reset,
  // Command handshake: a job is accepted in the cycle where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE, cmd_valid is
  // ignored in every other state and need not be dropped after accept.
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [ROWS_W-1:0]               cmd_rows,
  output logic                            wgt_rd_en,
  output logic [$clog2(ARRAY_DIM)-1:0]    wgt_rd_addr,
  input  logic [ARRAY_DIM*DATA_WIDTH-1:0] wgt_rd_data,
  output logic                            act_rd_en,
  output logic [ROWS_W-1:0]               act_rd_addr,
  input  logic [ARRAY_DIM*DATA_WIDTH-1:0] act_rd_data,
  output logic                            through,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0] top_out,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0] left_out,
  input  logic [ARRAY_DIM*DATA_WIDTH-1:0] res_in,
  output logic                            res_wr_en,
  output logic [ROWS_W-1:0]               res_wr_addr,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0] res_wr_data,
  output logic                            busy,
  output logic                            done,
  output seq_state_t                      dbg_state
`ifdef ARRAY_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                     perf_cycles
`endif
);

  localparam int VW       = ARRAY_DIM * DATA_WIDTH;
  localparam int AW       = $clog2(ARRAY_DIM);
  localparam int WCW      = $clog2(ARRAY_DIM + 1);
  localparam int LAT_W    = $clog2(ARRAY_LAT + ARRAY_DIM + 1);
  localparam int LAT_LOAD = ARRAY_LAT + ARRAY_DIM;

  seq_state_t        r_state;
  seq_state_t        w_next;
  logic [ROWS_W-1:0] r_rows;
  logic [WCW-1:0]    r_w_cnt;
  logic [ROWS_W-1:0] r_act_cnt;
  logic              r_act_valid;
  logic              r_through;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [ROWS_W-1:0] r_wr_left;
  logic [ROWS_W-1:0] r_wr_idx;
  logic              r_res_wr_en;
  logic [ROWS_W-1:0] r_res_wr_addr;
  logic [VW-1:0]     r_res_wr_data;
  logic              w_accept;
  logic              w_sample;
  logic [VW-1:0]     w_skew_in;
  logic [VW-1:0]     w_deskew;

  assign w_accept = cmd_valid && cmd_ready;
  // Counter parks at 1 while result rows are still due; each such cycle the
  // deskew output holds one aligned row ready for the output register.
  assign w_sample = (r_lat_cnt == LAT_W'(1)) && (r_wr_left != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    wgt_rd_en = 1'b0;
    act_rd_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) w_next = S_LOAD_W;
      end
      S_LOAD_W: begin
        wgt_rd_en = (r_w_cnt < WCW'(ARRAY_DIM));
        if (r_w_cnt == WCW'(ARRAY_DIM))
          w_next = (r_rows == '0) ? S_DONE : S_STREAM;
      end
      S_STREAM: begin
        act_rd_en = 1'b1;
        if (r_act_cnt == r_rows - ROWS_W'(1)) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_res_wr_en && (r_wr_left == '0)) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rows        <= '0;
      r_w_cnt       <= '0;
      r_act_cnt     <= '0;
      r_act_valid   <= 1'b0;
      r_through     <= 1'b0;
      r_lat_cnt     <= '0;
      r_wr_left     <= '0;
      r_wr_idx      <= '0;
      r_res_wr_en   <= 1'b0;
      r_res_wr_addr <= '0;
      r_res_wr_data <= '0;
    end else begin
      r_act_valid <= act_rd_en;
      r_through   <= wgt_rd_en;
      if (w_accept) begin
        r_rows    <= cmd_rows;
        r_w_cnt   <= '0;
        r_act_cnt <= '0;
        r_lat_cnt <= '0;
        r_wr_left <= cmd_rows;
        r_wr_idx  <= '0;
      end else begin
        if (r_state == S_LOAD_W) r_w_cnt <= r_w_cnt + WCW'(1);
        if (act_rd_en) r_act_cnt <= r_act_cnt + ROWS_W'(1);
        // First activation read starts the latency countdown for row 0.
        if (act_rd_en && (r_act_cnt == '0))
          r_lat_cnt <= LAT_W'(LAT_LOAD);
        else if (r_lat_cnt > LAT_W'(1))
          r_lat_cnt <= r_lat_cnt - LAT_W'(1);
        else if (w_sample && (r_wr_left == ROWS_W'(1)))
          r_lat_cnt <= '0;
        if (w_sample) begin
          r_wr_left <= r_wr_left - ROWS_W'(1);
          r_wr_idx  <= r_wr_idx + ROWS_W'(1);
        end
      end
      r_res_wr_en   <= w_sample;
      r_res_wr_addr <= w_sample ? r_wr_idx : '0;
      r_res_wr_data <= w_sample ? w_deskew : '0;
    end
  end

  assign wgt_rd_addr = wgt_rd_en ? AW'(ARRAY_DIM - 1 - int'(r_w_cnt)) : '0;
  assign act_rd_addr = act_rd_en ? r_act_cnt : '0;
  assign through     = r_through;
  assign top_out     = r_through ? wgt_rd_data : '0;
  assign w_skew_in   = r_act_valid ? act_rd_data : '0;
  assign res_wr_en   = r_res_wr_en;
  assign res_wr_addr = r_res_wr_addr;
  assign res_wr_data = r_res_wr_data;
  assign dbg_state   = r_state;

  lane_skew #(.N(ARRAY_DIM), .DATA_WIDTH(DATA_WIDTH), .REVERSE(0)) u_skew (
    .i_clk (clk),
    .i_rst (reset),
    .i_vec (w_skew_in),
    .o_vec (left_out)
  );

  lane_skew #(.N(ARRAY_DIM), .DATA_WIDTH(DATA_WIDTH), .REVERSE(1)) u_deskew (
    .i_clk (clk),
    .i_rst (reset),
    .i_vec (res_in),
    .o_vec (w_deskew)
  );

`ifdef ARRAY_SEQ_PERF_CNT_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       r_perf <= '0;
    else if (w_accept)               r_perf <= '0;
    else if (busy && (r_perf != '1)) r_perf <= r_perf + 32'd1;
  end

  assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_array_sequencer.sv
// Directed bench for array_sequencer at N=4, ARRAY_LAT=5 with weight/activation
// memory models and a 5-cycle loop-back from left_out to res_in.
module tb_array_sequencer;
  import array_seq_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int RW  = 16;
  localparam int LAT = 5;
  localparam int VW  = N * DW;
  localparam int NC  = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [RW-1:0] cmd_rows;
  logic          wgt_rd_en;
  logic [1:0]    wgt_rd_addr;
  logic [VW-1:0] wgt_rd_data;
  logic          act_rd_en;
  logic [RW-1:0] act_rd_addr;
  logic [VW-1:0] act_rd_data;
  logic          through;
  logic [VW-1:0] top_out;
  logic [VW-1:0] left_out;
  logic [VW-1:0] res_in;
  logic          res_wr_en;
  logic [RW-1:0] res_wr_addr;
  logic [VW-1:0] res_wr_data;
  logic          busy;
  logic          done;
  seq_state_t    dbg_state;
`ifdef ARRAY_SEQ_PERF_CNT_EN
  logic [31:0]   perf_cycles;
`endif

  always #5 clk = ~clk;

  array_sequencer #(
    .ARRAY_DIM(N), .DATA_WIDTH(DW), .ROWS_W(RW), .ARRAY_LAT(LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rows    (cmd_rows),
    .wgt_rd_en   (wgt_rd_en),
    .wgt_rd_addr (wgt_rd_addr),
    .wgt_rd_data (wgt_rd_data),
    .act_rd_en   (act_rd_en),
    .act_rd_addr (act_rd_addr),
    .act_rd_data (act_rd_data),
    .through     (through),
    .top_out     (top_out),
    .left_out    (left_out),
    .res_in      (res_in),
    .res_wr_en   (res_wr_en),
    .res_wr_addr (res_wr_addr),
    .res_wr_data (res_wr_data),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
`ifdef ARRAY_SEQ_PERF_CNT_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  // Buffer and array models
  logic [VW-1:0] wgt_mem [4];
  logic [VW-1:0] act_mem [4];
  logic [VW-1:0] lb [LAT];

  always @(posedge clk) begin
    wgt_rd_data <= wgt_rd_en ? wgt_mem[wgt_rd_addr] : 32'hDEADBEEF;
    act_rd_data <= act_rd_en ? act_mem[act_rd_addr[1:0]] : 32'hDEADBEEF;
    lb[0] <= left_out;
    for (int i = 1; i < LAT; i++) lb[i] <= lb[i-1];
  end
  assign res_in = lb[LAT-1];

  logic w_any_out;
  assign w_any_out = wgt_rd_en | (|wgt_rd_addr) | act_rd_en | (|act_rd_addr) |
                     through | (|top_out) | (|left_out) | res_wr_en |
                     (|res_wr_addr) | (|res_wr_data) | busy | done;

  // Per-cycle logs of one job window
  logic [63:0]   m_wgt_en, m_through, m_act_en, m_res_en, m_done, m_busy, m_ready, m_accept, m_any;
  logic [VW-1:0] l_top [NC];
  logic [VW-1:0] l_left [NC];
  logic [VW-1:0] l_res_data [NC];
  logic [RW-1:0] l_act_addr [NC];
  logic [RW-1:0] l_res_addr [NC];
  logic [1:0]    l_wgt_addr [NC];
  logic [31:0]   l_perf [NC];

  logic [VW-1:0] exp_q [$];
  int n_pass;
  int n_checks;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Starts at a negedge; cycle 0 is the cycle cmd_valid is first presented.
  task automatic run_job(input int m, input int ncyc, input int rst_at, input int hold_until);
    m_wgt_en = '0; m_through = '0; m_act_en = '0; m_res_en = '0;
    m_done = '0; m_busy = '0; m_ready = '0; m_accept = '0; m_any = '0;
    cmd_rows = RW'(m);
    for (int c = 0; c < ncyc; c++) begin
      cmd_valid = (c < hold_until);
      if (c == rst_at) reset = 1'b1;
      if (c == rst_at + 2) reset = 1'b0;
      #1;
      m_wgt_en[c]   = wgt_rd_en;
      m_through[c]  = through;
      m_act_en[c]   = act_rd_en;
      m_res_en[c]   = res_wr_en;
      m_done[c]     = done;
      m_busy[c]     = busy;
      m_ready[c]    = cmd_ready;
      m_accept[c]   = cmd_valid && cmd_ready;
      m_any[c]      = w_any_out;
      l_top[c]      = top_out;
      l_left[c]     = left_out;
      l_res_data[c] = res_wr_data;
      l_act_addr[c] = act_rd_addr;
      l_res_addr[c] = res_wr_addr;
      l_wgt_addr[c] = wgt_rd_addr;
`ifdef ARRAY_SEQ_PERF_CNT_EN
      l_perf[c]     = perf_cycles;
`else
      l_perf[c]     = '0;
`endif
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  // Expectations for an M=3 job observed over cycles 0..21
  task automatic verify_basic(input string p);
    logic [VW-1:0] row;
    logic [VW-1:0] exp_row;
    check_eq({p, "_wgt_en"},  m_wgt_en,  64'h1E);
    check_eq({p, "_through"}, m_through, 64'h3C);
    check_eq({p, "_act_en"},  m_act_en,  64'h1C0);
    check_eq({p, "_res_en"},  m_res_en,  64'h7_0000);
    check_eq({p, "_done"},    m_done,    64'h8_0000);
    check_eq({p, "_busy"},    m_busy,    64'hF_FFFE);
    check_eq({p, "_ready"},   m_ready,   64'h30_0001);
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("%s_wgt_addr_c%0d", p, 1 + i), l_wgt_addr[1+i], 64'(N - 1 - i));
      check_eq($sformatf("%s_top_c%0d", p, 2 + i), l_top[2+i], wgt_mem[N-1-i]);
    end
    check_eq({p, "_top_c6_zero"}, l_top[6], 0);
    for (int r = 0; r < 3; r++) begin
      check_eq($sformatf("%s_act_addr_c%0d", p, 6 + r), l_act_addr[6+r], 64'(r));
      check_eq($sformatf("%s_res_addr_c%0d", p, 16 + r), l_res_addr[16+r], 64'(r));
    end
    check_eq({p, "_left_c6_zero"},  l_left[6],  0);
    check_eq({p, "_left_c13_zero"}, l_left[13], 0);
    for (int k = 0; k < N; k++) begin
      row     = l_left[7+k];
      exp_row = act_mem[0];
      check_eq($sformatf("%s_left_lane%0d_c%0d", p, k, 7 + k), row[k*DW +: DW], exp_row[k*DW +: DW]);
    end
    exp_q.delete();
    for (int r = 0; r < 3; r++) exp_q.push_back(act_mem[r]);
    for (int c = 0; c < 22; c++) begin
      if (m_res_en[c]) begin
        if (exp_q.size() == 0) check_eq($sformatf("%s_res_extra_c%0d", p, c), 1, 0);
        else check_eq($sformatf("%s_res_data_c%0d", p, c), l_res_data[c], exp_q.pop_front());
      end
    end
    check_eq({p, "_res_q_left"}, 64'(exp_q.size()), 0);
  endtask

  initial begin
    n_pass    = 0;
    n_checks  = 0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_rows  = '0;
    wgt_mem[0] = 32'h11223344; wgt_mem[1] = 32'h55667788;
    wgt_mem[2] = 32'h99AABBCC; wgt_mem[3] = 32'hDDEEFF01;
    act_mem[0] = 32'h04030201; act_mem[1] = 32'h0A141E28;
    act_mem[2] = 32'hF0E1D2C3; act_mem[3] = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_any_out", w_any_out, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check_eq("post_rst_ready", cmd_ready, 1);
    check_eq("post_rst_any_out", w_any_out, 0);
    @(negedge clk);

    // Basic M=3 job with loop-back skew/deskew
    run_job(3, 22, 1000, 1);
    verify_basic("basic");
`ifdef ARRAY_SEQ_PERF_CNT_EN
    check_eq("perf_c20", l_perf[20], 19);
    check_eq("perf_c21", l_perf[21], 19);
`endif

    // M=0 job
    run_job(0, 10, 1000, 1);
    check_eq("m0_wgt_en",  m_wgt_en,  64'h1E);
    check_eq("m0_through", m_through, 64'h3C);
    check_eq("m0_act_en",  m_act_en,  64'h0);
    check_eq("m0_res_en",  m_res_en,  64'h0);
    check_eq("m0_done",    m_done,    64'h40);
    check_eq("m0_busy",    m_busy,    64'h7E);
    check_eq("m0_ready",   m_ready,   64'h381);
`ifdef ARRAY_SEQ_PERF_CNT_EN
    check_eq("m0_perf_hold_c0", l_perf[0], 19);
    check_eq("m0_perf_clr_c1",  l_perf[1], 0);
    check_eq("m0_perf_c9",      l_perf[9], 6);
`endif

    // Reset asserted at cycle 10 of an M=3 job
    run_job(3, 22, 10, 1);
    check_eq("midrst_any_c10",   m_any[10], 0);
    check_eq("midrst_any_after", m_any >> 10, 0);
    check_eq("midrst_res_en",    m_res_en, 64'h0);
    check_eq("midrst_done",      m_done,   64'h0);
    check_eq("midrst_busy",      m_busy,   64'h3FE);
    check_eq("midrst_ready",     m_ready,  64'h3F_FC01);

    // Fresh job after the mid-job reset
    run_job(3, 22, 1000, 1);
    verify_basic("post_rst");

    // cmd_valid held high across back-to-back jobs
    run_job(3, 63, 1000, 41);
    check_eq("hold_accept",  m_accept,  64'h0000_0100_0010_0001);
    check_eq("hold_through", m_through, 64'h0000_3C00_03C0_003C);
    check_eq("hold_res_en",  m_res_en,  64'h0700_0070_0007_0000);
    check_eq("hold_done",    m_done,    64'h0800_0080_0008_0000);
    check_eq("hold_overlap", m_through & m_res_en, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/array_sequencer.md
# array_sequencer

Controller that sequences one matrix job through the 256×256 systolic array: it loads weights with `through` held high, streams activation rows with per-lane skew, and deskews the array outputs into aligned result rows. It sits between the weight, activation and result buffers and the array's `top_in`/`left_in`/`down_out`/`through` pins. One command runs one job.

## Interface
- `ARRAY_DIM`, 256, array edge N (lanes per vector)
- `DATA_WIDTH`, 8, bits per lane
- `ROWS_W`, 16, width of row count and activation/result addresses
- `ARRAY_LAT`, 512, cycles from lane k at `left_out` to lane k valid at `res_in`
- `clk` in 1, sole clock
- `reset` in 1, asynchronous, active-high
- `cmd_valid` in 1, job request
- `cmd_ready` out 1, high only in IDLE
- `cmd_rows` in ROWS_W, activation row count M; sampled on accept
- `wgt_rd_en` out 1, weight buffer read strobe
- `wgt_rd_addr` out log2(N), weight row address
- `wgt_rd_data` in N*DATA_WIDTH, weight row; 1-cycle read latency
- `act_rd_en` out 1, activation read strobe
- `act_rd_addr` out ROWS_W, activation row address
- `act_rd_data` in N*DATA_WIDTH, activation row; 1-cycle read latency
- `through` out 1, to array; high only while weights shift
- `top_out` out N*DATA_WIDTH, to array `top_in`
- `left_out` out N*DATA_WIDTH, skewed activations to array `left_in`
- `res_in` in N*DATA_WIDTH, from array `down_out`
- `res_wr_en` out 1, result write strobe
- `res_wr_addr` out ROWS_W, result row address
- `res_wr_data` out N*DATA_WIDTH, deskewed result row
- `busy` out 1, high outside IDLE
- `done` out 1, one-cycle pulse at job end

## Operation
- States: IDLE → LOAD_W → STREAM → DRAIN → DONE → IDLE. If M=0: LOAD_W → DONE.
- Accept is `cmd_valid && cmd_ready`; `cmd_valid` is ignored outside IDLE.
- LOAD_W, N+1 cycles:
  - Reads weight rows N-1 down to 0, one per cycle, in the first N cycles.
  - `top_out` = `wgt_rd_data` passthrough.
  - `through` is registered so it is high exactly in the N cycles the data is valid.
- STREAM, M cycles: reads activation rows 0..M-1, one per cycle.
- Skew: lane k of the read data reaches `left_out` k cycles after it arrives.
  - Skew registers shift in zero when no read is in flight, so `left_out` is zero outside valid windows.
- Deskew: lane k of `res_in` is delayed N-1-k cycles, then passes through one output register that drives `res_wr_*`.
- Row-valid tracking uses a down-counter loaded with ARRAY_LAT+N, not a valid shift chain.
- DRAIN: waits for the last write. DONE: `done`=1 for one cycle.
- `res_wr_addr` increments per write, starting at 0.
- Reset, including mid-job:
  - State returns to IDLE and all counters and skew/deskew registers clear.
  - Every output goes to 0, except `cmd_ready`=1 after reset.
  - No partial write or `done` is produced.

## Timing
Cycle 0 is the accept cycle.
- Weight reads: cycles 1..N, address N-1-i at cycle 1+i.
- `through` high: cycles 2..N+1.
- Activation read of row r: cycle N+2+r.
- Lane k of row r at `left_out`: cycle N+3+r+k.
- Result write of row r: cycle t_r+ARRAY_LAT+N+1, where t_r is the row's read cycle.
- Last write W = 2N+M+ARRAY_LAT+2.
- `done` at W+1; `cmd_ready` at W+2.
- M=0: `done` at N+2.
- `busy` is high from cycle 1 through the `done` cycle.

## Configuration
- `ARRAY_SEQ_PERF_CNT_EN` defined:
  - Adds output `perf_cycles`, 32 bits.
  - Counts busy cycles of the current job, saturating at all-ones.
  - Holds its value after `done` and clears on the next accept and on reset.
- Undefined: no port, no counter logic.

## Structure
- Package `array_seq_pkg`:
  - state enum
  - lane typedef `logic [DATA_WIDTH-1:0]`
  - row-vector typedef
- Sub-module `lane_skew`:
  - Triangular per-lane delay line, parameters N, DATA_WIDTH and `REVERSE`.
  - `REVERSE`=0 gives lane k depth k; `REVERSE`=1 gives depth N-1-k.
  - Instantiated twice, once for skew and once for deskew.

## Test plan
Unless stated, N=4, ARRAY_LAT=5.
- Basic job, M=3:
  - Weight reads at cycles 1–4, addresses 3,2,1,0; `through` high cycles 2–5.
  - Activation reads at cycles 6,7,8.
  - Result writes at cycles 16,17,18, addresses 0,1,2; `done` at 19; `cmd_ready` at 20.
- Skew/deskew with a loop-back model (`res_in` = `left_out` delayed 5 cycles):
  - Activation row 0 = {1,2,3,4}: lane k appears on `left_out` at cycle 7+k.
  - `res_wr_data` at cycle 16 = {1,2,3,4}.
- M=0: `through` high cycles 2–5, no activation reads or writes, `done` at 6.
- Reset asserted at cycle 10 of the M=3 job:
  - All outputs go to 0 immediately and no writes follow.
  - A new job accepted after release reproduces the basic-job timing.
- `cmd_valid` held high through a job: a second accept occurs only at cycle 20; back-to-back jobs have no overlap of `through` and writes.
- With `ARRAY_SEQ_PERF_CNT_EN`: after the M=3 job, `perf_cycles`=19 and holds until the next accept.
